// File: rtl/cmp_arbiter_rv32i.sv
// Round-robin arbiter sharing one RV32I branch/SLT comparator between two ports.
// Define CMP_ARB_STATS_EN to build saturating grant/stall statistics counters.
module cmp_arbiter_rv32i #(
    parameter int WIDTH  = 32,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [1:0]        req_valid,
    input  logic [2:0]        req_op0,
    input  logic [2:0]        req_op1,
    input  logic [WIDTH-1:0]  req_a0,
    input  logic [WIDTH-1:0]  req_b0,
    input  logic [WIDTH-1:0]  req_a1,
    input  logic [WIDTH-1:0]  req_b1,
    output logic [1:0]        req_ready,
    output logic [1:0]        resp_valid,
    output logic              resp_taken,
    output logic              resp_err,
    output logic [STAT_W-1:0] stat_grant0,
    output logic [STAT_W-1:0] stat_grant1,
    output logic [STAT_W-1:0] stat_stall0,
    output logic [STAT_W-1:0] stat_stall1
);

    // Handshake: port i transfers when req_valid[i] && req_ready[i] in the same
    // cycle; req_ready is one-hot or zero and forced low while rst is high.
    logic             ptr_q, ptr_d;
    logic [1:0]       grant;
    logic [1:0]       resp_valid_q, resp_valid_d;
    logic             resp_taken_q, resp_taken_d;
    logic             resp_err_q, resp_err_d;

    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             cmp_eq, cmp_ltu, cmp_lt;
    logic             cmp_taken, cmp_err;

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;

    always_comb begin
        sel_op = grant[1] ? req_op1 : req_op0;
        sel_a  = grant[1] ? req_a1  : req_a0;
        sel_b  = grant[1] ? req_b1  : req_b0;
    end

    // Signed less-than from the unsigned result plus sign bits; no subtraction,
    // so it cannot be fooled by overflow.
    always_comb begin
        cmp_eq  = (sel_a == sel_b);
        cmp_ltu = (sel_a < sel_b);
        cmp_lt  = (sel_a[WIDTH-1] != sel_b[WIDTH-1]) ? sel_a[WIDTH-1] : cmp_ltu;
    end

    always_comb begin
        cmp_taken = 1'b0;
        cmp_err   = 1'b0;
        case (sel_op)
            3'b000:  cmp_taken = cmp_eq;
            3'b001:  cmp_taken = !cmp_eq;
            3'b100:  cmp_taken = cmp_lt;
            3'b101:  cmp_taken = !cmp_lt;
            3'b110:  cmp_taken = cmp_ltu;
            3'b111:  cmp_taken = !cmp_ltu;
            default: cmp_err   = 1'b1;
        endcase
    end

    // A flushed grant still advances the pointer but never produces a response.
    always_comb begin
        ptr_d        = ptr_q;
        resp_valid_d = 2'b00;
        resp_taken_d = resp_taken_q;
        resp_err_d   = resp_err_q;
        if (grant != 2'b00) begin
            ptr_d = grant[0];
            if (!flush) begin
                resp_valid_d = grant;
                resp_taken_d = cmp_taken;
                resp_err_d   = cmp_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= 1'b0;
            resp_valid_q <= 2'b00;
            resp_taken_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_taken_q <= resp_taken_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_taken = resp_taken_q;
    assign resp_err   = resp_err_q;

`ifdef CMP_ARB_STATS_EN
    logic [1:0][STAT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [1:0][STAT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (grant[i] && (grant_cnt_q[i] != '1))
                grant_cnt_d[i] = grant_cnt_q[i] + STAT_W'(1);
            if (req_valid[i] && !grant[i] && (stall_cnt_q[i] != '1))
                stall_cnt_d[i] = stall_cnt_q[i] + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_grant0 = grant_cnt_q[0];
    assign stat_grant1 = grant_cnt_q[1];
    assign stat_stall0 = stall_cnt_q[0];
    assign stat_stall1 = stall_cnt_q[1];
`else
    assign stat_grant0 = '0;
    assign stat_grant1 = '0;
    assign stat_stall0 = '0;
    assign stat_stall1 = '0;
`endif

endmodule

// File: tb/tb_cmp_arbiter_rv32i.sv
// Bench for cmp_arbiter_rv32i: directed plan steps plus random traffic against
// a cycle-level reference model (compile with CMP_ARB_STATS_EN for counters).
module tb_cmp_arbiter_rv32i;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  req_valid;
    logic [2:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic        resp_taken, resp_err;
    logic [15:0] stat_grant0, stat_grant1, stat_stall0, stat_stall1;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state.
    int          m_next_port = 0;
    logic [1:0]  m_valid = 2'b00;
    logic        m_taken = 1'b0;
    logic        m_err   = 1'b0;
    logic [15:0] m_grant [2];
    logic [15:0] m_stall [2];

    always #5 clk = ~clk;

    cmp_arbiter_rv32i #(.WIDTH(32), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_taken(resp_taken), .resp_err(resp_err),
        .stat_grant0(stat_grant0), .stat_grant1(stat_grant1),
        .stat_stall0(stat_stall0), .stat_stall1(stat_stall1)
    );

    // {err, taken} straight from the RV32I branch definitions.
    function automatic logic [1:0] ref_cond(input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return {1'b0, a == b};
            3'd1: return {1'b0, a != b};
            3'd4: return {1'b0, $signed(a) <  $signed(b)};
            3'd5: return {1'b0, $signed(a) >= $signed(b)};
            3'd6: return {1'b0, a <  b};
            3'd7: return {1'b0, a >= b};
            default: return 2'b10;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stats();
`ifdef CMP_ARB_STATS_EN
        check("stat_grant0", 32'(stat_grant0), 32'(m_grant[0]));
        check("stat_grant1", 32'(stat_grant1), 32'(m_grant[1]));
        check("stat_stall0", 32'(stat_stall0), 32'(m_stall[0]));
        check("stat_stall1", 32'(stat_stall1), 32'(m_stall[1]));
`else
        check("stat_zero", {stat_grant0, stat_grant1} | {stat_stall0, stat_stall1}, 32'd0);
`endif
    endtask

    // One clock cycle: drive, check grant, clock, check response and stats.
    task automatic cycle(input logic r, input logic f, input logic [1:0] v,
                         input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1);
        int          g;
        logic [1:0]  rc;
        @(negedge clk);
        rst = r; flush = f; req_valid = v;
        req_op0 = o0; req_a0 = a0; req_b0 = b0;
        req_op1 = o1; req_a1 = a1; req_b1 = b1;
        #1;
        if (r)            g = -1;
        else if (v == 2'b01) g = 0;
        else if (v == 2'b10) g = 1;
        else if (v == 2'b11) g = m_next_port;
        else              g = -1;
        check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));

        m_valid = 2'b00;
        if (r) begin
            m_next_port = 0; m_taken = 1'b0; m_err = 1'b0;
            for (int i = 0; i < 2; i++) begin m_grant[i] = '0; m_stall[i] = '0; end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (g == i && m_grant[i] != 16'hFFFF) m_grant[i]++;
                if (v[i] && g != i && m_stall[i] != 16'hFFFF) m_stall[i]++;
            end
            if (g >= 0) begin
                m_next_port = 1 - g;
                if (!f) begin
                    rc = (g == 0) ? ref_cond(o0, a0, b0) : ref_cond(o1, a1, b1);
                    m_valid = 2'b01 << g;
                    m_taken = rc[0];
                    m_err   = rc[1];
                end
            end
        end

        @(posedge clk); #1;
        check("resp_valid", 32'(resp_valid), 32'(m_valid));
        check("resp_taken", 32'(resp_taken), 32'(m_taken));
        check("resp_err",   32'(resp_err),   32'(m_err));
        check_stats();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);
        cycle(1'b1, 1'b0, 2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'(($urandom_range(0, 3)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 2'b00;
        req_op0 = '0; req_op1 = '0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;

        do_reset();
        check("reset_resp_valid", 32'(resp_valid), 32'd0);

        // Port 0 alone, eq 5 == 5.
        cycle(1'b0, 1'b0, 2'b01, 3'd0, 32'd5, 32'd5, 3'd0, 32'd0, 32'd0);
        check("eq_taken_const", 32'(resp_taken), 32'd1);

        // Both valid straight after reset: port 0 then port 1, no bubble.
        do_reset();
        cycle(1'b0, 1'b0, 2'b11, 3'd4, 32'hFFFF_FFFF, 32'd1, 3'd6, 32'hFFFF_FFFF, 32'd1);
        check("rr_first_valid", 32'(resp_valid), 32'b01);
        cycle(1'b0, 1'b0, 2'b10, 3'd4, 32'hFFFF_FFFF, 32'd1, 3'd6, 32'hFFFF_FFFF, 32'd1);
        check("rr_second_valid", 32'(resp_valid), 32'b10);
        check("rr_second_taken", 32'(resp_taken), 32'd0);

        // Overflow-prone signed compare.
        cycle(1'b0, 1'b0, 2'b01, 3'd4, 32'h8000_0000, 32'd1, 3'd0, 32'd0, 32'd0);
        check("lt_overflow", 32'(resp_taken), 32'd1);
        cycle(1'b0, 1'b0, 2'b01, 3'd5, 32'h8000_0000, 32'd1, 3'd0, 32'd0, 32'd0);
        check("ge_overflow", 32'(resp_taken), 32'd0);

        // Illegal op on port 1.
        cycle(1'b0, 1'b0, 2'b10, 3'd0, 32'd0, 32'd0, 3'd2, 32'd9, 32'd3);
        check("illegal_err", 32'(resp_err), 32'd1);
        idle();
        check("idle_hold_err", 32'(resp_err), 32'd1);

        // Reset during a grant, then both valid -> port 0 first.
        cycle(1'b0, 1'b0, 2'b01, 3'd0, 32'd1, 32'd1, 3'd0, 32'd0, 32'd0);
        cycle(1'b1, 1'b0, 2'b01, 3'd0, 32'd1, 32'd1, 3'd0, 32'd0, 32'd0);
        check("rst_grant_drop", 32'(resp_valid), 32'd0);
        cycle(1'b0, 1'b0, 2'b11, 3'd1, 32'd1, 32'd2, 3'd1, 32'd3, 32'd3);
        check("after_rst_port0", 32'(resp_valid), 32'b01);

        // Flush during a grant to port 0, then both valid -> port 1 first.
        cycle(1'b0, 1'b1, 2'b01, 3'd0, 32'd7, 32'd7, 3'd0, 32'd0, 32'd0);
        check("flush_drop", 32'(resp_valid), 32'd0);
        cycle(1'b0, 1'b0, 2'b11, 3'd0, 32'd7, 32'd7, 3'd7, 32'd3, 32'd3);
        check("after_flush_port1", 32'(resp_valid), 32'b10);

        // Six cycles of contention from reset.
        do_reset();
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'b0, 2'b11, 3'd6, 32'd1, 32'd2, 3'd7, 32'd1, 32'd2);
`ifdef CMP_ARB_STATS_EN
        check("stat6_grant0", 32'(stat_grant0), 32'd3);
        check("stat6_grant1", 32'(stat_grant1), 32'd3);
        check("stat6_stall0", 32'(stat_stall0), 32'd3);
        check("stat6_stall1", 32'(stat_stall1), 32'd3);
`else
        check("stat6_zero", {stat_grant0, stat_stall1}, 32'd0);
`endif

        // Random traffic with occasional flush and rare reset.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 60) == 0), ($urandom_range(0, 9) == 0),
                  2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
                  3'($urandom_range(0, 7)), rand_operand(), rand_operand());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cmp_arbiter_rv32i.md
Name: cmp_arbiter_rv32i

Overview:
Shares one 32-bit RV32I comparator datapath between two requesters: port 0 is branch resolution and port 1 is the ALU SLT/SLTU path. Round-robin arbitration grants at most one request per cycle. The comparison result is registered and returned one cycle after the grant. The block sits between decode/execute and the shared comparator instance.

Parameters:
WIDTH, 32, operand width; only 32 is supported.
STAT_W, 16, width of the optional statistics counters.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
flush  in  1  kills the in-flight response; arbitration is unaffected
req_valid  in  2  per-port request valid; bit i belongs to port i
req_op0  in  3  port 0 condition, RV32I branch funct3 encoding
req_op1  in  3  port 1 condition, same encoding
req_a0, req_b0  in  32 each  port 0 operands
req_a1, req_b1  in  32 each  port 1 operands
req_ready  out  2  per-port grant, combinational in the request cycle
resp_valid  out  2  per-port response strobe, one cycle wide
resp_taken  out  1  condition result for the responding port
resp_err  out  1  illegal op code in the responding request
stat_grant0, stat_grant1  out  STAT_W each  grant counters (optional feature)
stat_stall0, stat_stall1  out  STAT_W each  stall counters (optional feature)

Behaviour:
- Reset (rst=1 at a clk edge):
  - resp_valid=0, resp_taken=0, resp_err=0.
  - Priority pointer = port 0.
  - Stat counters = 0.
  - req_ready=0 while rst is high.
- Request handshake:
  - A request transfers when req_valid[i] && req_ready[i] in the same cycle.
  - The requester holds op and operands stable until it is granted.
  - req_ready is one-hot or zero.
- Arbitration:
  - Only one valid port: that port is granted.
  - Both ports valid: the port named by the pointer is granted.
  - After any grant, the pointer moves to the other port.
  - With no grant, the pointer holds.
- Datapath and latency:
  - The granted operands drive the shared comparator in the grant cycle.
  - On the next edge: resp_valid[granted]=1, and resp_taken/resp_err are registered.
  - Latency is exactly 1 cycle. Throughput is 1 compare per cycle.
- Condition decode (op):
  - 000 eq, 001 neq, 100 lt, 101 ge, 110 ltu, 111 geu.
  - 010, 011 are illegal: resp_taken=0, resp_err=1.
- Signed compare:
  - lt = (a[31]!=b[31]) ? a[31] : ltu; ge = !lt.
  - This is overflow-safe; do not derive lt from the sign of a-b.
- Outputs on idle cycles: resp_valid=0; resp_taken and resp_err hold their last values.
- Flush:
  - A response captured in the flush cycle is dropped: resp_valid=0 next cycle.
  - Grants still happen and the pointer still advances; a grant made during flush is lost.
- Reset during a grant cycle: no response the following cycle, and the pointer returns to port 0.
- Back-to-back grants to alternating ports produce consecutive single-cycle resp_valid pulses with no bubbles.

Optional Feature:
Macro: CMP_ARB_STATS_EN

With the macro defined:
- stat_grantN increments on every grant to port N.
- stat_stallN increments each cycle in which req_valid[N]=1 and req_ready[N]=0.
- All counters saturate at all-ones.
- All counters clear on rst only (not on flush).

Without the macro:
- No counter registers are built.
- stat_* outputs are constant 0.

Test Plan:
- Reset, then port 0 only, op=000, a=5, b=5 -> req_ready=01 same cycle; next cycle resp_valid=01, resp_taken=1, resp_err=0.
- Both ports valid from the first cycle after reset; port 0 op=100 a=0xFFFFFFFF b=1; port 1 op=110 a=0xFFFFFFFF b=1:
  - Cycle 0 grants port 0; cycle 1 grants port 1 (req_ready=01 then 10).
  - Responses: resp_valid=01 taken=1 in cycle 1, then resp_valid=10 taken=0 in cycle 2.
- Port 0 op=100 with a=0x80000000, b=0x00000001 -> taken=1; op=101 with the same operands -> taken=0 (overflow case).
- Port 1 op=010 -> resp_valid=10, resp_taken=0, resp_err=1.
- Grant to port 0 with rst=1 in the same cycle -> resp_valid=00 next cycle; afterwards both ports valid -> port 0 granted first. Repeat with flush=1 instead of rst -> resp_valid=00 next cycle and pointer = port 1.
- With CMP_ARB_STATS_EN, both ports held valid 6 cycles -> stat_grant0=3, stat_grant1=3, stat_stall0=3, stat_stall1=3. Without the macro -> all stat_* read 0.
